// File: rtl/datapath_ctrl_fsm.sv
// Multi-cycle Moore controller for the register-file/shifter/ALU datapath with LDR/STR
// through a req/ack memory handshake. Build option: define CTRL_HALT_EN to decode 111 as HALT.
module datapath_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic       mem_ack,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       loadm,
    output logic       mem_req,
    output logic       mem_we,
    output logic       err,
    output logic       halted
);

    // A zero timeout still needs a one-bit counter to keep the logic legal.
    localparam int unsigned CNT_W = (TO_W == 0) ? 1 : TO_W;
    localparam bit          TO_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_WAIT,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_GET_D,
        S_ALU,
        S_WB,
        S_ADDR,
        S_LDM,
        S_PASS,
        S_MEM_RD,
        S_MEM_WR,
        S_ERR
`ifdef CTRL_HALT_EN
        , S_HALT
`endif
    } state_t;

    // Instruction class latched in DECODE; selects the shared states' routing and ALU strobes.
    typedef enum logic [2:0] {
        K_ALU,
        K_CMP,
        K_ONE,
        K_LDR,
        K_STR
    } kind_t;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       write;
        logic       loadm;
        logic       mem_req;
        logic       mem_we;
        logic       err;
    } ctrl_t;

    state_t           state;
    state_t           nxt_state;
    kind_t            kind;
    kind_t            nxt_kind;
    logic [CNT_W-1:0] cnt;
    ctrl_t            ctrl;
    logic             timeout_hit;
    logic             rd_ack;

`ifdef CTRL_HALT_EN
    logic             halted_q;
`endif

    // Strobe pattern of a state; registered one cycle early from the next state.
    function automatic ctrl_t decode_out(input state_t st, input kind_t k);
        ctrl_t o;
        o = '0;
        case (st)
            S_WAIT:   o.w = 1'b1;
            S_WR_IMM: begin
                o.write = 1'b1;
                o.vsel  = 2'b10;
                o.nsel  = 3'b100;
            end
            S_GET_A:  begin
                o.loada = 1'b1;
                o.nsel  = 3'b100;
            end
            S_GET_B:  begin
                o.loadb = 1'b1;
                o.nsel  = 3'b001;
            end
            S_GET_D:  begin
                o.loadb = 1'b1;
                o.nsel  = 3'b010;
            end
            S_ALU:    begin
                o.loads = 1'b1;
                if (k != K_CMP) begin
                    o.loadc = 1'b1;
                    o.asel  = (k == K_ONE);
                end
            end
            S_WB:     begin
                o.write = 1'b1;
                o.vsel  = 2'b00;
                o.nsel  = 3'b010;
            end
            S_ADDR:   begin
                o.loadc = 1'b1;
                o.bsel  = 1'b1;
            end
            S_LDM:    o.loadm = 1'b1;
            S_PASS:   begin
                o.loadc = 1'b1;
                o.asel  = 1'b1;
            end
            S_MEM_RD: o.mem_req = 1'b1;
            S_MEM_WR: begin
                o.mem_req = 1'b1;
                o.mem_we  = 1'b1;
            end
            S_ERR:    o.err = 1'b1;
            default:  o = '0;
        endcase
        return o;
    endfunction

    // Next-state and instruction-class decode.
    always_comb begin
        nxt_state   = state;
        nxt_kind    = kind;
        timeout_hit = TO_EN && (cnt == TO_LAST);
        case (state)
            S_WAIT:   if (s) nxt_state = S_DECODE;
            S_DECODE: begin
                nxt_state = S_ERR;
                case ({opcode, op})
                    5'b110_10: nxt_state = S_WR_IMM;
                    5'b110_00,
                    5'b101_11: begin
                        nxt_state = S_GET_B;
                        nxt_kind  = K_ONE;
                    end
                    5'b101_00,
                    5'b101_10: begin
                        nxt_state = S_GET_A;
                        nxt_kind  = K_ALU;
                    end
                    5'b101_01: begin
                        nxt_state = S_GET_A;
                        nxt_kind  = K_CMP;
                    end
                    5'b011_00: begin
                        nxt_state = S_GET_A;
                        nxt_kind  = K_LDR;
                    end
                    5'b100_00: begin
                        nxt_state = S_GET_A;
                        nxt_kind  = K_STR;
                    end
                    default: begin
`ifdef CTRL_HALT_EN
                        if (opcode == 3'b111) nxt_state = S_HALT;
`endif
                    end
                endcase
            end
            S_WR_IMM: nxt_state = S_WAIT;
            S_GET_A:  nxt_state = (kind == K_LDR || kind == K_STR) ? S_ADDR : S_GET_B;
            S_GET_B:  nxt_state = S_ALU;
            S_ALU:    nxt_state = (kind == K_CMP) ? S_WAIT : S_WB;
            S_WB:     nxt_state = S_WAIT;
            S_ADDR:   nxt_state = S_LDM;
            S_LDM:    nxt_state = (kind == K_LDR) ? S_MEM_RD : S_GET_D;
            S_GET_D:  nxt_state = S_PASS;
            S_PASS:   nxt_state = S_MEM_WR;
            S_MEM_RD,
            S_MEM_WR: begin
                // An ack on the final allowed cycle still completes the access.
                if (mem_ack)          nxt_state = S_WAIT;
                else if (timeout_hit) nxt_state = S_ERR;
            end
            S_ERR:    nxt_state = S_ERR;
`ifdef CTRL_HALT_EN
            S_HALT:   nxt_state = S_HALT;
`endif
            default:  nxt_state = S_ERR;
        endcase
    end

    // State, instruction class, timeout counter and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            kind  <= K_ALU;
            cnt   <= '0;
            ctrl  <= decode_out(S_WAIT, K_ALU);
`ifdef CTRL_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state <= nxt_state;
            kind  <= nxt_kind;
            ctrl  <= decode_out(nxt_state, nxt_kind);
            if ((state == S_MEM_RD || state == S_MEM_WR) && !mem_ack) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
`ifdef CTRL_HALT_EN
            halted_q <= (nxt_state == S_HALT);
`endif
        end
    end

    // Read data is valid in the ack cycle, so writeback overlays the MEM_RD strobes then.
    assign rd_ack  = (state == S_MEM_RD) && mem_ack;

    assign w       = ctrl.w;
    assign nsel    = rd_ack ? 3'b010 : ctrl.nsel;
    assign vsel    = rd_ack ? 2'b11  : ctrl.vsel;
    assign write   = ctrl.write | rd_ack;
    assign loada   = ctrl.loada;
    assign loadb   = ctrl.loadb;
    assign loadc   = ctrl.loadc;
    assign loads   = ctrl.loads;
    assign asel    = ctrl.asel;
    assign bsel    = ctrl.bsel;
    assign loadm   = ctrl.loadm;
    assign mem_req = ctrl.mem_req;
    assign mem_we  = ctrl.mem_we;
    assign err     = ctrl.err;

`ifdef CTRL_HALT_EN
    assign halted  = halted_q;
`else
    assign halted  = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Scoreboard bench for datapath_ctrl_fsm: per-cycle expected strobe vectors are queued with
// each instruction and compared as the controller steps through it.
module tb_datapath_ctrl_fsm;

    typedef logic [17:0] vec_t;

    // {w, nsel, vsel, loada loadb loadc loads asel bsel write loadm mem_req mem_we err halted}
    localparam vec_t V_WAIT = {1'b1, 3'b000, 2'b00, 12'b0000_0000_0000};
    localparam vec_t V_DEC  = {1'b0, 3'b000, 2'b00, 12'b0000_0000_0000};
    localparam vec_t V_IMM  = {1'b0, 3'b100, 2'b10, 12'b0000_0010_0000};
    localparam vec_t V_GETA = {1'b0, 3'b100, 2'b00, 12'b1000_0000_0000};
    localparam vec_t V_GETB = {1'b0, 3'b001, 2'b00, 12'b0100_0000_0000};
    localparam vec_t V_GETD = {1'b0, 3'b010, 2'b00, 12'b0100_0000_0000};
    localparam vec_t V_ALU  = {1'b0, 3'b000, 2'b00, 12'b0011_0000_0000};
    localparam vec_t V_ALU1 = {1'b0, 3'b000, 2'b00, 12'b0011_1000_0000};
    localparam vec_t V_CMP  = {1'b0, 3'b000, 2'b00, 12'b0001_0000_0000};
    localparam vec_t V_WB   = {1'b0, 3'b010, 2'b00, 12'b0000_0010_0000};
    localparam vec_t V_ADDR = {1'b0, 3'b000, 2'b00, 12'b0010_0100_0000};
    localparam vec_t V_LDM  = {1'b0, 3'b000, 2'b00, 12'b0000_0001_0000};
    localparam vec_t V_PASS = {1'b0, 3'b000, 2'b00, 12'b0010_1000_0000};
    localparam vec_t V_RD   = {1'b0, 3'b000, 2'b00, 12'b0000_0000_1000};
    localparam vec_t V_RDA  = {1'b0, 3'b010, 2'b11, 12'b0000_0010_1000};
    localparam vec_t V_WR   = {1'b0, 3'b000, 2'b00, 12'b0000_0000_1100};
    localparam vec_t V_ERR  = {1'b0, 3'b000, 2'b00, 12'b0000_0000_0010};
    localparam vec_t V_HALT = {1'b0, 3'b000, 2'b00, 12'b0000_0000_0001};

    logic       clk = 1'b0;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       mem_ack;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel, write, loadm;
    logic       mem_req, mem_we, err, halted;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sq[$];

    datapath_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .s       (s),
        .opcode  (opcode),
        .op      (op),
        .mem_ack (mem_ack),
        .w       (w),
        .nsel    (nsel),
        .vsel    (vsel),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .write   (write),
        .loadm   (loadm),
        .mem_req (mem_req),
        .mem_we  (mem_we),
        .err     (err),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    function automatic vec_t observe();
        return {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, loadm,
                mem_req, mem_we, err, halted};
    endfunction

    task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic push(input vec_t v, input int n);
        for (int i = 0; i < n; i++) sq.push_back(v);
    endtask

    // One queued entry per cycle. s_mode: 0 never, 1 first cycle only, 2 all but last cycle.
    task automatic drain(input string name, input int ack_idx, input int s_mode);
        int   i;
        vec_t e;
        i = 0;
        while (sq.size() > 0) begin
            e       = sq.pop_front();
            s       = (s_mode == 1 && i == 0) || (s_mode == 2 && sq.size() > 0);
            mem_ack = (i == ack_idx);
            #2;
            check_eq($sformatf("%s[%0d]", name, i), observe(), e);
            @(posedge clk);
            #1;
            i++;
        end
        s       = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic issue(input logic [2:0] opc, input logic [1:0] o);
        opcode = opc;
        op     = o;
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(V_WAIT, 1);
        drain(name, -1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        s       = 1'b0;
        mem_ack = 1'b0;
        opcode  = 3'b000;
        op      = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        push(V_WAIT, 1);
        drain("reset", -1, 0);
        reset = 1'b0;
        push(V_WAIT, 2);
        drain("idle", -1, 0);

        issue(3'b101, 2'b10);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_GETA, 1); push(V_GETB, 1);
        push(V_ALU, 1); push(V_WB, 1); push(V_WAIT, 1);
        drain("and", -1, 1);

        issue(3'b101, 2'b00);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_GETA, 1); push(V_GETB, 1);
        push(V_ALU, 1); push(V_WB, 1); push(V_WAIT, 1);
        drain("add", -1, 1);

        issue(3'b101, 2'b01);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_GETA, 1); push(V_GETB, 1);
        push(V_CMP, 1); push(V_WAIT, 1);
        drain("cmp", -1, 1);

        issue(3'b101, 2'b11);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_GETB, 1); push(V_ALU1, 1);
        push(V_WB, 1); push(V_WAIT, 1);
        drain("mvn", -1, 1);

        issue(3'b110, 2'b00);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_GETB, 1); push(V_ALU1, 1);
        push(V_WB, 1); push(V_WAIT, 1);
        drain("mov_rd", -1, 1);

        issue(3'b110, 2'b10);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_IMM, 1); push(V_WAIT, 1);
        drain("mov_imm", -1, 1);

        // s held high: WAIT lasts a single cycle between instructions
        issue(3'b110, 2'b10);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_IMM, 1);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_IMM, 1); push(V_WAIT, 1);
        drain("s_held", -1, 2);

        issue(3'b011, 2'b00);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_GETA, 1); push(V_ADDR, 1);
        push(V_LDM, 1); push(V_RD, 3); push(V_RDA, 1); push(V_WAIT, 1);
        drain("ldr_w3", 8, 1);

        issue(3'b011, 2'b00);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_GETA, 1); push(V_ADDR, 1);
        push(V_LDM, 1); push(V_RDA, 1); push(V_WAIT, 1);
        drain("ldr_w0", 5, 1);

        // ack on the last allowed cycle completes without error
        issue(3'b011, 2'b00);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_GETA, 1); push(V_ADDR, 1);
        push(V_LDM, 1); push(V_RD, 15); push(V_RDA, 1); push(V_WAIT, 1);
        drain("ldr_edge", 20, 1);

        issue(3'b100, 2'b00);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_GETA, 1); push(V_ADDR, 1);
        push(V_LDM, 1); push(V_GETD, 1); push(V_PASS, 1); push(V_WR, 2);
        push(V_WAIT, 1);
        drain("str", 8, 1);

        issue(3'b100, 2'b00);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_GETA, 1); push(V_ADDR, 1);
        push(V_LDM, 1); push(V_GETD, 1); push(V_PASS, 1); push(V_WR, 2);
        drain("str_pre_rst", -1, 1);
        do_reset("rst_mem_wr");

        issue(3'b100, 2'b00);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_GETA, 1); push(V_ADDR, 1);
        push(V_LDM, 1); push(V_GETD, 1); push(V_PASS, 1); push(V_WR, 16);
        push(V_ERR, 3);
        drain("str_timeout", -1, 1);
        push(V_ERR, 3);
        drain("err_sticky", 0, 2);
        do_reset("rst_err");

`ifdef CTRL_HALT_EN
        issue(3'b111, 2'b00);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_HALT, 3);
        drain("op111", -1, 1);
`else
        issue(3'b111, 2'b00);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_ERR, 3);
        drain("op111", -1, 1);
`endif
        do_reset("rst_111");

        issue(3'b000, 2'b00);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_ERR, 2);
        drain("illegal_000", -1, 1);
        do_reset("rst_000");

        issue(3'b110, 2'b01);
        push(V_WAIT, 1); push(V_DEC, 1); push(V_ERR, 2);
        drain("illegal_110_01", -1, 1);
        do_reset("rst_110_01");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
